// File: rtl/inst_trace_checker.sv
// Instruction-address trace checker: compares each retired InstAdd against a loadable
// expected-address table and drives periodic IRQ stimulus into the core during a run.

module inst_trace_irq_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic             i_live,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_width,
  output logic             o_irq
);
  logic [CNT_W-1:0] r_k;
  logic             r_irq;
  logic [CNT_W-1:0] w_per;
  logic             w_hit;

  assign w_per = (i_period == '0) ? CNT_W'(1) : i_period;
  // k >= P-W evaluated as k+W >= P so that W >= P needs no underflow special case
  assign w_hit = ({1'b0, r_k} + {1'b0, i_width}) >= {1'b0, w_per};
  assign o_irq = r_irq;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_k   <= '0;
      r_irq <= 1'b0;
    end else begin
      if (i_clr)      r_k <= '0;
      else if (i_run) r_k <= (r_k >= w_per - CNT_W'(1)) ? '0 : r_k + CNT_W'(1);
      r_irq <= i_live & i_en & w_hit;
    end
  end
endmodule

module inst_trace_checker #(
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int IDX_W        = $clog2(DEPTH),
  parameter int CNT_W        = 16,
  parameter int IRQ_CH       = 2,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                    clk,
  input  logic                    RESET_N,
  input  logic                    load_we,
  input  logic [IDX_W-1:0]        load_idx,
  input  logic [ADDR_W-1:0]       load_data,
  input  logic [IDX_W:0]          trace_len,
  input  logic                    start,
  input  logic                    step,
  input  logic [ADDR_W-1:0]       InstAdd,
  input  logic [IRQ_CH-1:0]       irq_en,
  input  logic [IRQ_CH*CNT_W-1:0] irq_period,
  input  logic [IRQ_CH*CNT_W-1:0] irq_width,
  output logic [IRQ_CH-1:0]       IRQ,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [IDX_W:0]          cur_idx,
  output logic [CNT_W-1:0]        mismatch_count,
  output logic [IDX_W:0]          first_fail_idx,
  output logic [ADDR_W-1:0]       first_fail_addr,
  output logic                    fail_seen
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W:0] DEPTH_V = (IDX_W+1)'(DEPTH);

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_mem [DEPTH];
  logic [IDX_W:0]     r_len, r_cur_idx, r_ff_idx;
  logic [CNT_W-1:0]   r_mcnt;
  logic [ADDR_W-1:0]  r_ff_addr;
  logic               r_fail_seen;
  logic               w_start, w_cmp, w_miss, w_live;
  logic [IDX_W:0]     w_idx_inc;

  assign w_start   = start && (r_state != RUN);
  assign w_cmp     = step && (r_state == RUN);
  assign w_miss    = w_cmp && (InstAdd != r_mem[r_cur_idx[IDX_W-1:0]]);
  assign w_idx_inc = r_cur_idx + (IDX_W+1)'(1);
  // IRQ is suppressed in the cycle after the run's final edge, hence the look-ahead
  assign w_live    = (r_state == RUN) && (w_state_nxt == RUN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = (trace_len == '0) ? DONE : RUN;
      RUN: if (w_cmp && ((w_idx_inc == r_len) || ((STOP_ON_FAIL != 0) && w_miss)))
             w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_cur_idx   <= '0;
      r_mcnt      <= '0;
      r_ff_idx    <= '0;
      r_ff_addr   <= '0;
      r_fail_seen <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_len       <= trace_len;
        r_cur_idx   <= '0;
        r_mcnt      <= '0;
        r_ff_idx    <= '0;
        r_ff_addr   <= '0;
        r_fail_seen <= 1'b0;
      end else if (w_cmp) begin
        r_cur_idx <= w_idx_inc;
        if (w_miss) begin
          if (r_mcnt != '1) r_mcnt <= r_mcnt + CNT_W'(1);
          if (!r_fail_seen) begin
            r_ff_idx  <= r_cur_idx;
            r_ff_addr <= InstAdd;
          end
          r_fail_seen <= 1'b1;
        end
      end
    end
  end

  // Table contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (load_we && (r_state != RUN) && ({1'b0, load_idx} < DEPTH_V))
      r_mem[load_idx] <= load_data;
  end

  for (genvar c = 0; c < IRQ_CH; c++) begin : g_irq
    inst_trace_irq_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .RESET_N  (RESET_N),
      .i_clr    (w_start),
      .i_run    (r_state == RUN),
      .i_live   (w_live),
      .i_en     (irq_en[c]),
      .i_period (irq_period[c*CNT_W +: CNT_W]),
      .i_width  (irq_width[c*CNT_W +: CNT_W]),
      .o_irq    (IRQ[c])
    );
  end

  assign busy            = (r_state == RUN);
  assign done            = (r_state == DONE);
  assign pass            = done & ~r_fail_seen;
  assign cur_idx         = r_cur_idx;
  assign mismatch_count  = r_mcnt;
  assign first_fail_idx  = r_ff_idx;
  assign first_fail_addr = r_ff_addr;
  assign fail_seen       = r_fail_seen;
endmodule
